// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mult_state_t;

    // Counter must hold 0..WIDTH-1 with one spare bit of headroom.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/add_sub_n.sv
// Combinational (WIDTH+1)-bit adder/subtractor; operands are sign- or zero-extended by mode.
module add_sub_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             Signed_Mode,
    output logic [WIDTH:0]   O
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;

    assign a_ext = {Signed_Mode & A[WIDTH-1], A};
    assign b_ext = {Signed_Mode & B[WIDTH-1], B};
    assign O     = Sub ? (a_ext - b_ext) : (a_ext + b_ext);

endmodule

// File: rtl/seq_mult_n.sv
// WIDTH x WIDTH shift-add multiplier, signed or unsigned, one multiplier bit per ADD/SHIFT pair.
module seq_mult_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product,
    output logic               X
);

    localparam int CNT_W = cnt_width(WIDTH);

    mult_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;

    logic             last_bit;
    logic [WIDTH:0]   sum;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // The multiplier's top bit carries negative weight in signed mode.
    add_sub_n #(.WIDTH(WIDTH)) u_add_sub (
        .A           (a_q),
        .B           (m_q),
        .Sub         (mode_q & last_bit),
        .Signed_Mode (mode_q),
        .O           (sum)
    );

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    m_d     = Multiplicand;
                    b_d     = Multiplier;
                    mode_d  = Signed_Mode;
                    a_d     = '0;
                    x_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (b_q[0]) begin
                    a_d = sum[WIDTH-1:0];
                    x_d = sum[WIDTH];
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
                if (!mode_q) x_d = 1'b0;
                if (last_bit) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ADD;
                end
            end
            DONE: begin
                if (!Start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign Busy    = (state_q == ADD) || (state_q == SHIFT);
    assign Done    = (state_q == DONE);
    assign Product = {a_q, b_q};
    assign X       = x_q;

endmodule
